// File: rtl/mips32_pkg.sv
// Shared definitions for the pipelined MIPS32 core and its program loader:
// loader state/err encodings, header size, core opcodes and instruction types.
package mips32_pkg;

  typedef enum logic [2:0] {
    LD_HDR   = 3'd0,
    LD_CHECK = 3'd1,
    LD_DATA  = 3'd2,
    LD_CSUM  = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } ld_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CSUM  = 2'b01,
    ERR_RANGE = 2'b10
  } ld_err_e;

  localparam int HDR_BYTES = 4;

  // Core opcodes
  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] HLT   = 6'b111111;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;

  // Instruction types as tracked by the core pipeline
  localparam logic [2:0] RR_ALU = 3'b000;
  localparam logic [2:0] RM_ALU = 3'b001;
  localparam logic [2:0] LOAD   = 3'b010;
  localparam logic [2:0] STORE  = 3'b011;
  localparam logic [2:0] BRANCH = 3'b100;
  localparam logic [2:0] HALT   = 3'b101;

endpackage

// File: rtl/mips32_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; pulses word_valid the
// cycle after the 4th byte of a word is taken.
module mips32_word_assembler (
  input  logic        clk1,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  din,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] sr;

  assign last_lane = (lane == 2'd3);

  always_ff @(posedge clk1) begin
    if (clear) begin
      lane       <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        sr   <= {sr[15:0], din};
        lane <= lane + 2'd1;
        if (last_lane) begin
          word       <= {sr, din};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses header, writes words into Mem, verifies
// the XOR checksum and releases the core with the image base as start PC.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  input  logic              run_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] pc_init,
  output logic              done,
  output logic [1:0]        err
);

  ld_state_e   state, nxt;
  logic [1:0]  hcnt;
  logic [15:0] cnt, base, wcnt;
  logic [7:0]  xacc;
  logic        accept, last_lane, range_bad, csum_ok;
  logic [16:0] span;

  assign rx_ready = ~reset & (state == LD_HDR || state == LD_DATA || state == LD_CSUM);
  // A byte presented together with load_req belongs to the abandoned frame.
  assign accept   = rx_valid & rx_ready & ~load_req;

  assign span      = {1'b0, base} + {1'b0, cnt};
  assign range_bad = (base[15:ADDR_W] != '0) || (span > (17'd1 << ADDR_W));
  assign csum_ok   = (rx_data == xacc);

  mips32_word_assembler u_asm (
    .clk1       (clk1),
    .clear      (reset | load_req),
    .byte_en    (accept && state == LD_DATA),
    .din        (rx_data),
    .last_lane  (last_lane),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_comb begin
    nxt = state;
    case (state)
      LD_HDR:   if (accept && hcnt == 2'(HDR_BYTES - 1)) nxt = LD_CHECK;
      LD_CHECK: begin
        if (range_bad)      nxt = LD_ERR;
        else if (cnt == '0) nxt = LD_CSUM;
        else                nxt = LD_DATA;
      end
      LD_DATA:  if (accept && last_lane && (wcnt + 16'd1 == cnt)) nxt = LD_CSUM;
      LD_CSUM:  if (accept) nxt = csum_ok ? LD_DONE : LD_ERR;
      default:  nxt = state;
    endcase
    if (load_req) nxt = LD_HDR;
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state    <= LD_HDR;
      hcnt     <= '0;
      cnt      <= '0;
      base     <= '0;
      wcnt     <= '0;
      xacc     <= '0;
      mem_addr <= '0;
      cpu_run  <= 1'b0;
      pc_init  <= '0;
      done     <= 1'b0;
      err      <= ERR_NONE;
    end else if (load_req) begin
      state   <= LD_HDR;
      hcnt    <= '0;
      cnt     <= '0;
      base    <= '0;
      wcnt    <= '0;
      xacc    <= '0;
      cpu_run <= 1'b0;
      done    <= 1'b0;
      err     <= ERR_NONE;
    end else begin
      state <= nxt;
      if (accept) xacc <= xacc ^ rx_data;
      case (state)
        LD_HDR: if (accept) begin
          hcnt <= hcnt + 2'd1;
          case (hcnt)
            2'd0:    cnt[15:8]  <= rx_data;
            2'd1:    cnt[7:0]   <= rx_data;
            2'd2:    base[15:8] <= rx_data;
            default: base[7:0]  <= rx_data;
          endcase
        end
        LD_CHECK: if (range_bad) err <= ERR_RANGE;
        LD_DATA: if (accept && last_lane) begin
          mem_addr <= base[ADDR_W-1:0] + wcnt[ADDR_W-1:0];
          wcnt     <= wcnt + 16'd1;
        end
        LD_CSUM: if (accept) begin
          if (csum_ok) begin
            done    <= 1'b1;
            pc_init <= base[ADDR_W-1:0];
            cpu_run <= AUTO_RUN;
          end else begin
            err <= ERR_CSUM;
          end
        end
        LD_DONE: if (run_req) cpu_run <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
